corelet_ctrl: RTL

Sequencing controller for one corelet (L0 input FIFO, 8x8 MAC array, OFIFO, SFP). For each kernel position kij it loads weights and then activations from the activation/weight SRAM (xmem) into L0. It pushes them through the array with the correct `inst` encoding, drains the OFIFO into the partial-sum SRAM (pmem), and pulses `done` after the last kij. It sits between the top-level testbench/host and the corelet, replacing hand-written instruction streams.

---
 rtl/corelet_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/corelet_ctrl.sv
// Sequencer for one corelet: per kernel position, loads weights then activations
// from xmem into L0, drives the MAC array and drains the OFIFO into pmem.
module corelet_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_kij = 9,
  parameter int len_nij = 16,
  parameter int w_base  = 0,
  parameter int a_base  = 128,
  parameter int xaddr_w = 11,
  parameter int paddr_w = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(len_kij)-1:0] kij,
  output logic                       xmem_cen,
  output logic [xaddr_w-1:0]         xmem_addr,
  output logic                       l0_wr,
  output logic                       l0_rd,
  input  logic                       l0_o_full,
  output logic [33:0]                inst,
  input  logic                       ofifo_o_valid,
  output logic                       ofifo_rd,
  output logic                       pmem_wen,
  output logic [paddr_w-1:0]         pmem_addr
);

  localparam int kij_w     = $clog2(len_kij);
  localparam int bound_a   = (row > col) ? row : col;
  localparam int bound_b   = ((row + col) > len_nij) ? (row + col) : len_nij;
  localparam int cnt_bound = (bound_a > bound_b) ? bound_a : bound_b;
  localparam int cnt_w     = $clog2(cnt_bound);

  if (psum_bw < bw) begin : g_width_check
    $error("corelet_ctrl: psum_bw must be at least bw");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WPUSH, S_WSETTLE, S_ALOAD, S_EXEC, S_DRAIN, S_NEXT
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [cnt_w-1:0]     cnt_r, cnt_nxt_s;
  logic [kij_w-1:0]     kij_r, kij_nxt_s;
  logic [xaddr_w-1:0]   w_off_r, w_off_nxt_s;
  logic [paddr_w-1:0]   p_off_r, p_off_nxt_s;
  logic                 l0_wr_r;

  logic                 busy_s, done_s, xmem_cen_s, l0_rd_s, kload_s, exec_s, ofifo_rd_s;
  logic [xaddr_w-1:0]   xmem_addr_s;
  logic [paddr_w-1:0]   pmem_addr_s;

  // State, phase counter, kij counter and the running kij*col / kij*len_nij offsets.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= cnt_w'(0);
      kij_r   <= kij_w'(0);
      w_off_r <= xaddr_w'(0);
      p_off_r <= paddr_w'(0);
      l0_wr_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      kij_r   <= kij_nxt_s;
      w_off_r <= w_off_nxt_s;
      p_off_r <= p_off_nxt_s;
      l0_wr_r <= xmem_cen_s;
    end
  end

  // Next-state, counter updates and output decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    kij_nxt_s   = kij_r;
    w_off_nxt_s = w_off_r;
    p_off_nxt_s = p_off_r;
    busy_s      = 1'b1;
    done_s      = 1'b0;
    xmem_cen_s  = 1'b0;
    xmem_addr_s = xaddr_w'(0);
    l0_rd_s     = 1'b0;
    kload_s     = 1'b0;
    exec_s      = 1'b0;
    ofifo_rd_s  = 1'b0;
    pmem_addr_s = paddr_w'(0);

    case (state_r)
      S_IDLE: begin
        busy_s      = 1'b0;
        cnt_nxt_s   = cnt_w'(0);
        kij_nxt_s   = kij_w'(0);
        w_off_nxt_s = xaddr_w'(0);
        p_off_nxt_s = paddr_w'(0);
        if (start) begin
          state_nxt_s = S_WLOAD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end

      S_WLOAD: begin
        xmem_addr_s = xaddr_w'(w_base) + w_off_r + xaddr_w'(cnt_r);
        // A full L0 freezes the read index, so the address simply holds.
        if (!l0_o_full) begin
          xmem_cen_s = 1'b1;
          if (cnt_r == cnt_w'(row - 1)) begin
            cnt_nxt_s   = cnt_w'(0);
            state_nxt_s = S_WPUSH;
          end else begin
            cnt_nxt_s = cnt_r + cnt_w'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      S_WPUSH: begin
        l0_rd_s = 1'b1;
        kload_s = 1'b1;
        if (cnt_r == cnt_w'(col - 1)) begin
          cnt_nxt_s   = cnt_w'(0);
          state_nxt_s = S_WSETTLE;
        end else begin
          cnt_nxt_s = cnt_r + cnt_w'(1);
        end
      end

      S_WSETTLE: begin
        if (cnt_r == cnt_w'(row + col - 1)) begin
          cnt_nxt_s   = cnt_w'(0);
          state_nxt_s = S_ALOAD;
        end else begin
          cnt_nxt_s = cnt_r + cnt_w'(1);
        end
      end

      S_ALOAD: begin
        xmem_addr_s = xaddr_w'(a_base) + xaddr_w'(cnt_r);
        if (!l0_o_full) begin
          xmem_cen_s = 1'b1;
          if (cnt_r == cnt_w'(len_nij - 1)) begin
            cnt_nxt_s   = cnt_w'(0);
            state_nxt_s = S_EXEC;
          end else begin
            cnt_nxt_s = cnt_r + cnt_w'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      S_EXEC: begin
        l0_rd_s = 1'b1;
        exec_s  = 1'b1;
        if (cnt_r == cnt_w'(len_nij - 1)) begin
          cnt_nxt_s   = cnt_w'(0);
          state_nxt_s = S_DRAIN;
        end else begin
          cnt_nxt_s = cnt_r + cnt_w'(1);
        end
      end

      S_DRAIN: begin
        pmem_addr_s = p_off_r + paddr_w'(cnt_r);
        if (ofifo_o_valid) begin
          ofifo_rd_s = 1'b1;
          if (cnt_r == cnt_w'(len_nij - 1)) begin
            cnt_nxt_s   = cnt_w'(0);
            state_nxt_s = S_NEXT;
          end else begin
            cnt_nxt_s = cnt_r + cnt_w'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      S_NEXT: begin
        if (kij_r == kij_w'(len_kij - 1)) begin
          done_s      = 1'b1;
          busy_s      = 1'b0;
          kij_nxt_s   = kij_w'(0);
          w_off_nxt_s = xaddr_w'(0);
          p_off_nxt_s = paddr_w'(0);
          state_nxt_s = S_IDLE;
        end else begin
          kij_nxt_s   = kij_r + kij_w'(1);
          w_off_nxt_s = w_off_r + xaddr_w'(col);
          p_off_nxt_s = p_off_r + paddr_w'(len_nij);
          state_nxt_s = S_WLOAD;
        end
      end

      default: begin
        busy_s      = 1'b0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  assign busy      = busy_s;
  assign done      = done_s;
  assign kij       = kij_r;
  assign xmem_cen  = xmem_cen_s;
  assign xmem_addr = xmem_addr_s;
  assign l0_wr     = l0_wr_r;
  assign l0_rd     = l0_rd_s;
  assign inst      = {32'd0, exec_s, kload_s};
  assign ofifo_rd  = ofifo_rd_s;
  assign pmem_wen  = ofifo_rd_s;
  assign pmem_addr = pmem_addr_s;

endmodule
